// File: rtl/fifo_stream_reader.sv
// Read-side controller for a synchronous FIFO: issues reads, absorbs the 1-cycle read
// latency in a 2-entry buffer and presents the words as a framed valid/ready stream.
module fifo_stream_reader #(
  parameter int width     = 8,
  parameter int burst_len = 4,
  parameter int cnt_w     = ($clog2(burst_len) > 0) ? $clog2(burst_len) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [width-1:0] fifo_rdata,
  output logic             fifo_ren,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_last,
  output logic             burst_done
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam logic [cnt_w-1:0] LAST_BEAT = cnt_w'(burst_len - 1);

  occ_e             occ_q, occ_d;
  logic             inflight_q;
  logic [cnt_w-1:0] beat_q, beat_d;
  logic [width-1:0] head_q, head_d;
  logic [width-1:0] tail_q, tail_d;
  logic             done_q, done_d;
  logic             pop;
  logic             capture;
  logic [2:0]       committed;

  assign out_valid  = (occ_q != OCC_EMPTY);
  assign out_data   = head_q;
  assign out_last   = out_valid && (beat_q == LAST_BEAT);
  assign burst_done = done_q;

  assign pop     = out_valid && out_ready;
  assign capture = inflight_q;

  // Words held plus in flight, less the one leaving this cycle; a read may only
  // be issued while that leaves room in the 2-entry buffer.
  assign committed = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign fifo_ren  = !rst && en && !fifo_empty && (committed < 3'd2);

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    beat_d = beat_q;
    done_d = pop && out_last;
    unique case ({capture, pop})
      2'b10: begin
        unique case (occ_q)
          OCC_EMPTY: begin
            head_d = fifo_rdata;
            occ_d  = OCC_ONE;
          end
          OCC_ONE: begin
            tail_d = fifo_rdata;
            occ_d  = OCC_TWO;
          end
          default: ;
        endcase
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
      end
      2'b11: begin
        // Head leaves while a new word lands: it goes behind any remaining word.
        if (occ_q == OCC_ONE) begin
          head_d = fifo_rdata;
        end else begin
          head_d = tail_q;
          tail_d = fifo_rdata;
        end
      end
      default: ;
    endcase
    if (pop) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= OCC_EMPTY;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      done_q     <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= fifo_ren;
      beat_q     <= beat_d;
      done_q     <= done_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: two instances (burst_len 4 and 1), each fed by a FIFO
// model, checked every cycle against a word-sequence reference model.
module tb_fifo_stream_reader;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       en_s  = 2'b00;
  logic [1:0]       rdy_s = 2'b00;
  logic [1:0]       empty_s;
  logic [1:0][7:0]  rdata_s;
  logic [1:0]       ren_s;
  logic [1:0]       ov_s;
  logic [1:0][7:0]  odata_s;
  logic [1:0]       olast_s;
  logic [1:0]       bd_s;

  int errors = 0;
  int checks = 0;

  // FIFO model storage
  logic [7:0] fmem [2][1024];
  int         fw [2];
  int         fr [2];

  // Reference model: every word read from the FIFO, in order, with its read cycle
  logic [7:0] rd_word [2][1024];
  int         rd_cyc  [2][1024];
  int         rd_cnt  [2];
  int         pop_idx [2];
  int         beat    [2];
  bit         done_exp[2];
  int         cyc = 0;

  // Observed statistics used by literal end-of-phase checks
  int acc_cnt  [2];
  int last_cnt [2];
  int done_cnt [2];

  always #5 clk = ~clk;

  fifo_stream_reader #(.width(8), .burst_len(4)) dut0 (
    .clk(clk), .rst(rst), .en(en_s[0]), .fifo_empty(empty_s[0]), .fifo_rdata(rdata_s[0]),
    .fifo_ren(ren_s[0]), .out_valid(ov_s[0]), .out_ready(rdy_s[0]), .out_data(odata_s[0]),
    .out_last(olast_s[0]), .burst_done(bd_s[0])
  );

  fifo_stream_reader #(.width(8), .burst_len(1)) dut1 (
    .clk(clk), .rst(rst), .en(en_s[1]), .fifo_empty(empty_s[1]), .fifo_rdata(rdata_s[1]),
    .fifo_ren(ren_s[1]), .out_valid(ov_s[1]), .out_ready(rdy_s[1]), .out_data(odata_s[1]),
    .out_last(olast_s[1]), .burst_done(bd_s[1])
  );

  assign empty_s[0] = (fr[0] >= fw[0]);
  assign empty_s[1] = (fr[1] >= fw[1]);

  // Registered-read FIFO: rdata only changes on an accepted read
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ren_s[k] && (fr[k] < fw[k])) begin
        rdata_s[k] <= fmem[k][fr[k]];
        fr[k]      <= fr[k] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model to the next edge
  always @(negedge clk) begin
    int outst;
    int bl;
    bit ev;
    bit pp;
    bit er;
    for (int k = 0; k < 2; k++) begin
      bl    = (k == 0) ? 4 : 1;
      outst = rd_cnt[k] - pop_idx[k];
      pp    = 1'b0;
      if (!rst) begin
        ev = (outst > 0) && (cyc >= rd_cyc[k][pop_idx[k]] + 2);
        chk($sformatf("out_valid[%0d]", k), 32'(ov_s[k]), 32'(ev));
        if (ev) begin
          chk($sformatf("out_data[%0d]", k), 32'(odata_s[k]), 32'(rd_word[k][pop_idx[k]]));
          chk($sformatf("out_last[%0d]", k), 32'(olast_s[k]), 32'(beat[k] == bl - 1));
        end
        chk($sformatf("burst_done[%0d]", k), 32'(bd_s[k]), 32'(done_exp[k]));
        pp = ev && rdy_s[k];
        er = en_s[k] && (fr[k] < fw[k]) && ((outst - int'(pp)) < 2);
        chk($sformatf("fifo_ren[%0d]", k), 32'(ren_s[k]), 32'(er));
        chk($sformatf("held_le2[%0d]", k), 32'(outst <= 2), 32'd1);
      end else begin
        chk($sformatf("ren_in_rst[%0d]", k), 32'(ren_s[k]), 32'd0);
      end
      if (ov_s[k] && rdy_s[k] && !rst) begin
        acc_cnt[k]++;
        if (olast_s[k]) last_cnt[k]++;
      end
      if (bd_s[k] && !rst) done_cnt[k]++;
      if (rst) begin
        pop_idx[k]  = rd_cnt[k];
        beat[k]     = 0;
        done_exp[k] = 1'b0;
      end else begin
        done_exp[k] = pp && (beat[k] == bl - 1);
        if (pp) begin
          pop_idx[k]++;
          beat[k] = (beat[k] + 1) % bl;
        end
      end
      if (ren_s[k] && (fr[k] < fw[k])) begin
        rd_word[k][rd_cnt[k]] = fmem[k][fr[k]];
        rd_cyc[k][rd_cnt[k]]  = cyc;
        rd_cnt[k]++;
      end
    end
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [7:0] d);
    fmem[k][fw[k]] = d;
    fw[k]++;
  endtask

  int pushed0;
  int pushed1;

  initial begin
    rst = 1'b1;
    step(2);
    chk("rst_out_valid", 32'(ov_s), 32'd0);
    chk("rst_out_last", 32'(olast_s), 32'd0);
    chk("rst_burst_done", 32'(bd_s), 32'd0);
    chk("rst_out_data", 32'(odata_s[0]), 32'd0);
    chk("rst_fifo_ren", 32'(ren_s), 32'd0);

    // Preloaded FIFO, no backpressure
    for (int i = 0; i < 8; i++) push(0, 8'(8'h11 + i));
    rst = 1'b0; en_s[0] = 1'b1; rdy_s[0] = 1'b1;
    step(1);
    chk("t1_latency_c1", 32'(ov_s[0]), 32'd0);
    step(1);
    chk("t1_latency_c2", 32'(ov_s[0]), 32'd1);
    chk("t1_first_word", 32'(odata_s[0]), 32'h11);
    step(12);
    chk("t1_accepted", 32'(acc_cnt[0]), 32'd8);
    chk("t1_lasts", 32'(last_cnt[0]), 32'd2);
    chk("t1_dones", 32'(done_cnt[0]), 32'd2);

    // Backpressure
    rdy_s[0] = 1'b0;
    push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    step(6);
    chk("t2_hold_valid", 32'(ov_s[0]), 32'd1);
    chk("t2_hold_data", 32'(odata_s[0]), 32'hA1);
    chk("t2_hold_ren", 32'(ren_s[0]), 32'd0);
    rdy_s[0] = 1'b1;
    step(6);
    chk("t2_accepted", 32'(acc_cnt[0]), 32'd11);

    // FIFO runs dry mid-burst
    push(0, 8'hB0); push(0, 8'hB1);
    step(8);
    push(0, 8'hB2); push(0, 8'hB3);
    step(8);
    chk("t3_accepted", 32'(acc_cnt[0]), 32'd15);

    // en pulsed for a single cycle
    en_s[0] = 1'b0;
    for (int i = 0; i < 7; i++) push(0, 8'(8'hC0 + i));
    step(1);
    en_s[0] = 1'b1;
    step(1);
    en_s[0] = 1'b0;
    step(5);
    chk("t4_idle_valid", 32'(ov_s[0]), 32'd0);
    chk("t4_idle_ren", 32'(ren_s[0]), 32'd0);
    chk("t4_left_in_fifo", 32'(fw[0] - fr[0]), 32'd6);
    en_s[0] = 1'b1;
    step(12);
    chk("t4_accepted", 32'(acc_cnt[0]), 32'd22);

    // Reset with a word in flight and a partial burst
    rdy_s[0] = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 8'(8'hD0 + i));
    step(1);
    rst = 1'b1;
    #1;
    chk("t5_ren_in_rst", 32'(ren_s[0]), 32'd0);
    step(1);
    chk("t5_valid_after_rst", 32'(ov_s[0]), 32'd0);
    chk("t5_last_after_rst", 32'(olast_s[0]), 32'd0);
    chk("t5_done_after_rst", 32'(bd_s[0]), 32'd0);
    rst = 1'b0; rdy_s[0] = 1'b1;
    step(10);
    chk("t5_accepted", 32'(acc_cnt[0]), 32'd25);

    // Random traffic on both instances; burst_len=1 instance gets 32 words
    pushed0 = 0;
    pushed1 = 0;
    for (int i = 0; i < 300; i++) begin
      en_s[0]  = ($urandom_range(0, 3) != 0);
      rdy_s[0] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        push(0, 8'($urandom));
        pushed0++;
      end
      en_s[1]  = 1'b1;
      rdy_s[1] = 1'($urandom_range(0, 1));
      if (pushed1 < 32 && $urandom_range(0, 3) == 0) begin
        push(1, 8'($urandom));
        pushed1++;
      end
      step(1);
    end
    while (pushed1 < 32) begin
      push(1, 8'($urandom));
      pushed1++;
    end
    en_s = 2'b11; rdy_s = 2'b11;
    step(250);
    chk("rand0_all_delivered", 32'(acc_cnt[0]), 32'(25 + pushed0));
    chk("bl1_delivered", 32'(acc_cnt[1]), 32'd32);
    chk("bl1_all_last", 32'(last_cnt[1]), 32'd32);
    chk("bl1_all_done", 32'(done_cnt[1]), 32'd32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
